// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multi-cycle CPU control path:
// state encodings, opcodes, datapath mux codes and the control word.
package cpu_ctrl_pkg;

  localparam int STATE_BITS = 4;
  localparam int OPC_BITS   = 6;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [OPC_BITS-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_BITS-1:0] OP_J     = 6'h02;
  localparam logic [OPC_BITS-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_BITS-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_BITS-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_BITS-1:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // True for every opcode the DECODE state knows how to dispatch.
  function automatic logic is_known_op(input logic [OPC_BITS-1:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// State -> control word decoder. Pure combinational; the only input other
// than the state is the effective memory-ready, used to gate the FETCH
// write enables so the PC and IR load exactly once per fetch.
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Control word per state; anything not listed stays 0 (incl. unused codes).
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.i_or_d   = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_src        = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.reg_write  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle CPU control unit: state register, next-state logic and the
// reset masking of the control word produced by ctrl_output_decode.
//
// state   | meaning
// --------+---------------------------------------------------------
// FETCH   | read instruction at PC; load IR and PC+4 when memory ready
// DECODE  | read registers, compute branch target into ALUOut; dispatch
// MEMADR  | compute load/store address A + sign-ext imm
// MEMRD   | read data memory at ALUOut until ready
// MEMWB   | write MDR into rt
// MEMWR   | write B to data memory at ALUOut until ready
// EXECUTE | R-type ALU operation on A, B
// ALUWB   | write ALUOut into rd
// BRANCH  | compare A, B; load PC from ALUOut if equal
// JUMP    | load PC with jump target
// ADDIEX  | A + sign-ext imm
// ADDIWB  | write ALUOut into rt
module multi_cycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter int OP_W     = 6,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [OP_W-1:0]    i_op,
  input  logic               i_mem_ready,
  output logic               o_pc_write,
  output logic               o_pc_write_cond,
  output logic               o_i_or_d,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_ir_write,
  output logic               o_mem_to_reg,
  output logic               o_reg_dst,
  output logic               o_reg_write,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [1:0]         o_alu_op,
  output logic [1:0]         o_pc_src,
  output logic               o_illegal,
  output logic [STATE_W-1:0] o_state
);

  state_t state_q, state_d;
  ctrl_t  ctrl_raw, ctrl;
  logic   ready;

  // With single-cycle memory every memory state completes immediately.
  assign ready = MEM_WAIT ? i_mem_ready : 1'b1;

  // State register; reset returns to FETCH at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic. i_op is only looked at in DECODE and MEMADR, where
  // the IR is stable, so no separate opcode register is kept.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:   state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((i_op == OP_LW) || (i_op == OP_SW)) state_d = S_MEMADR;
        else if (i_op == OP_RTYPE)              state_d = S_EXECUTE;
        else if (i_op == OP_BEQ)                state_d = S_BRANCH;
        else if (i_op == OP_J)                  state_d = S_JUMP;
        else if (i_op == OP_ADDI)               state_d = S_ADDIEX;
        else                                    state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (i_op == OP_LW)      state_d = S_MEMRD;
        else if (i_op == OP_SW) state_d = S_MEMWR;
        else                    state_d = S_FETCH;
      end
      S_MEMRD:   state_d = ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  ctrl_output_decode u_dec (
    .state_i     (state_q),
    .mem_ready_i (ready),
    .ctrl_o      (ctrl_raw)
  );

  // While reset is held the state already reads FETCH, but FETCH would
  // still drive mem_read, so the whole word is blanked here.
  always_comb begin
    ctrl = ctrl_raw;
    if (i_rst) ctrl = '0;
  end

  assign o_pc_write      = ctrl.pc_write;
  assign o_pc_write_cond = ctrl.pc_write_cond;
  assign o_i_or_d        = ctrl.i_or_d;
  assign o_mem_read      = ctrl.mem_read;
  assign o_mem_write     = ctrl.mem_write;
  assign o_ir_write      = ctrl.ir_write;
  assign o_mem_to_reg    = ctrl.mem_to_reg;
  assign o_reg_dst       = ctrl.reg_dst;
  assign o_reg_write     = ctrl.reg_write;
  assign o_alu_src_a     = ctrl.alu_src_a;
  assign o_alu_src_b     = ctrl.alu_src_b;
  assign o_alu_op        = ctrl.alu_op;
  assign o_pc_src        = ctrl.pc_src;

  assign o_illegal = ~i_rst && (state_q == S_DECODE) && !is_known_op(i_op);
  assign o_state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Directed bench for multi_cycle_control_fsm. Control outputs are packed
// into one 17-bit word and compared against hand-written values.
module tb_multi_cycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  multi_cycle_control_fsm dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_op            (op),
    .i_mem_ready     (ready),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_i_or_d        (i_or_d),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_ir_write      (ir_write),
    .o_mem_to_reg    (mem_to_reg),
    .o_reg_dst       (reg_dst),
    .o_reg_write     (reg_write),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_pc_src        (pc_src),
    .o_illegal       (illegal),
    .o_state         (state)
  );

  // Packed view of all control outputs, in a fixed order.
  wire [16:0] ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_src, illegal};

  function automatic logic [16:0] cw(
    input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa,
    input logic [1:0] sb, aop, psrc,
    input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, psrc, ill};
  endfunction

  //                                pcw pcwc iord mr mw irw m2r rd rw sa  sb     aop    psrc  ill
  localparam logic [16:0] W_ZERO   = '0;
  wire [16:0] W_FETCH_RDY = cw(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
  wire [16:0] W_FETCH_WT  = cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
  wire [16:0] W_DECODE    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0);
  wire [16:0] W_DEC_ILL   = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 1);
  wire [16:0] W_MEMADR    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0);
  wire [16:0] W_MEMRD     = cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
  wire [16:0] W_MEMWB     = cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0);
  wire [16:0] W_MEMWR     = cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
  wire [16:0] W_EXECUTE   = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 0);
  wire [16:0] W_ALUWB     = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0);
  wire [16:0] W_BRANCH    = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 0);
  wire [16:0] W_JUMP      = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0);
  wire [16:0] W_ADDIEX    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0);
  wire [16:0] W_ADDIWB    = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check state and control word at the current point, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_ctl);
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
    chk({tag, ".ctl"}, {15'd0, ctl}, {15'd0, exp_ctl});
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst   = 1'b1;
    op    = 6'h23;
    ready = 1'b1;
    #3;
    chk("reset.state", {28'd0, state}, 32'd0);
    chk("reset.ctl", {15'd0, ctl}, 32'd0);
    #9;
    rst = 1'b0;   // released at t=12, next edge at t=15

    // lw, ready = 1: 0,1,2,3,4,0
    cyc("lw.f",   4'd0, W_FETCH_RDY);
    cyc("lw.d",   4'd1, W_DECODE);
    cyc("lw.ma",  4'd2, W_MEMADR);
    cyc("lw.rd",  4'd3, W_MEMRD);
    cyc("lw.wb",  4'd4, W_MEMWB);

    // sw with ready low for 3 cycles in MEMWR
    op = 6'h2B;
    cyc("sw.f",   4'd0, W_FETCH_RDY);
    cyc("sw.d",   4'd1, W_DECODE);
    cyc("sw.ma",  4'd2, W_MEMADR);
    ready = 1'b0;
    cyc("sw.wr0", 4'd5, W_MEMWR);
    cyc("sw.wr1", 4'd5, W_MEMWR);
    cyc("sw.wr2", 4'd5, W_MEMWR);
    ready = 1'b1;
    cyc("sw.wr3", 4'd5, W_MEMWR);

    // FETCH with ready delayed two cycles, then beq
    op    = 6'h04;
    ready = 1'b0;
    cyc("fw.f0",  4'd0, W_FETCH_WT);
    cyc("fw.f1",  4'd0, W_FETCH_WT);
    ready = 1'b1;
    cyc("fw.f2",  4'd0, W_FETCH_RDY);
    cyc("beq.d",  4'd1, W_DECODE);
    cyc("beq.br", 4'd8, W_BRANCH);

    // j
    op = 6'h02;
    cyc("j.f",    4'd0, W_FETCH_RDY);
    cyc("j.d",    4'd1, W_DECODE);
    cyc("j.j",    4'd9, W_JUMP);

    // R-type
    op = 6'h00;
    cyc("r.f",    4'd0, W_FETCH_RDY);
    cyc("r.d",    4'd1, W_DECODE);
    cyc("r.ex",   4'd6, W_EXECUTE);
    cyc("r.wb",   4'd7, W_ALUWB);

    // addi
    op = 6'h08;
    cyc("ad.f",   4'd0, W_FETCH_RDY);
    cyc("ad.d",   4'd1, W_DECODE);
    cyc("ad.ex",  4'd10, W_ADDIEX);
    cyc("ad.wb",  4'd11, W_ADDIWB);

    // illegal opcode: one-cycle pulse in DECODE, back to FETCH
    op = 6'h3F;
    cyc("il.f",   4'd0, W_FETCH_RDY);
    cyc("il.d",   4'd1, W_DEC_ILL);
    ready = 1'b0;
    cyc("il.back", 4'd0, W_FETCH_WT);
    ready = 1'b1;

    // reset in the middle of MEMRD
    op = 6'h23;
    cyc("rr.f",   4'd0, W_FETCH_RDY);
    cyc("rr.d",   4'd1, W_DECODE);
    cyc("rr.ma",  4'd2, W_MEMADR);
    ready = 1'b0;
    #1;
    chk("rr.rd.state", {28'd0, state}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rr.abort.state", {28'd0, state}, 32'd0);
    chk("rr.abort.ctl", {15'd0, ctl}, 32'd0);
    ready = 1'b1;
    @(posedge clk);
    #2;
    chk("rr.hold.state", {28'd0, state}, 32'd0);
    chk("rr.hold.ctl", {15'd0, ctl}, 32'd0);
    rst = 1'b0;
    cyc("rr.rel", 4'd0, W_FETCH_RDY);
    cyc("rr.d2",  4'd1, W_DECODE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
